// File: rtl/entry_free_list.sv
`default_nettype none
// ==========================================================================
// entry_free_list : multi-port FIFO free list of LSQ entry indices
// Optional duplicate/overflow retire checking: ENTRY_FREE_LIST_CHECK_EN
// Revision: 1.0
// ==========================================================================
module entry_free_list #(
  parameter int DEPTH   = 16,
  parameter int ALLOC_W = 2,
  parameter int RET_W   = 2,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(ALLOC_W + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [CNT_W-1:0]         alloc_req_cnt,
  output logic                     alloc_grant,
  output logic [ALLOC_W*IDX_W-1:0] alloc_entry,
  input  logic [RET_W-1:0]         retire_valid,
  input  logic [RET_W*IDX_W-1:0]   retire_entry,
  output logic [IDX_W:0]           num_free,
  output logic                     is_empty,
  output logic                     is_full,
  output logic                     err
);

  localparam int SUM_W = IDX_W + 2;

  logic [IDX_W-1:0] list [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;

  logic [SUM_W-1:0] alloc_amt;
  logic [SUM_W-1:0] ret_cnt;
  logic [RET_W-1:0] ret_accept;
  logic [IDX_W-1:0] ret_slot [RET_W];

`ifdef ENTRY_FREE_LIST_CHECK_EN
  logic [DEPTH-1:0] is_free;
  logic [SUM_W-1:0] base;
  logic             ret_err;
  logic             dup;
`endif

  assign alloc_grant = !rst && !flush && (alloc_req_cnt != '0) &&
                       (alloc_req_cnt <= CNT_W'(ALLOC_W)) &&
                       ((IDX_W+1)'(alloc_req_cnt) <= num_free);

  assign alloc_amt = alloc_grant ? SUM_W'(alloc_req_cnt) : '0;

  assign is_empty = (num_free == (IDX_W+1)'(DEPTH));
  assign is_full  = (num_free == '0);

  always_comb begin
    alloc_entry = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_entry[k*IDX_W +: IDX_W] = list[head + IDX_W'(k)];
    end
  end

  // Compact accepted retire lanes in ascending order starting at tail.
  always_comb begin
    ret_accept = '0;
    ret_cnt    = '0;
`ifdef ENTRY_FREE_LIST_CHECK_EN
    ret_err = 1'b0;
    dup     = 1'b0;
    base    = SUM_W'(num_free) - alloc_amt;
`endif
    for (int i = 0; i < RET_W; i++) begin
      ret_slot[i] = tail + ret_cnt[IDX_W-1:0];
`ifdef ENTRY_FREE_LIST_CHECK_EN
      if (retire_valid[i]) begin
        dup = 1'b0;
        for (int j = 0; j < i; j++) begin
          if (retire_valid[j] &&
              (retire_entry[j*IDX_W +: IDX_W] == retire_entry[i*IDX_W +: IDX_W]))
            dup = 1'b1;
        end
        if (!is_free[retire_entry[i*IDX_W +: IDX_W]] && !dup &&
            ((base + ret_cnt) < SUM_W'(DEPTH)))
          ret_accept[i] = 1'b1;
        else
          ret_err = 1'b1;
      end
`else
      ret_accept[i] = retire_valid[i];
`endif
      if (ret_accept[i]) ret_cnt = ret_cnt + SUM_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) list[i] <= IDX_W'(i);
      head     <= '0;
      tail     <= '0;
      num_free <= (IDX_W+1)'(DEPTH);
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) list[i] <= IDX_W'(i);
      head     <= '0;
      tail     <= '0;
      num_free <= (IDX_W+1)'(DEPTH);
    end else begin
      if (alloc_grant) head <= head + IDX_W'(alloc_req_cnt);
      for (int i = 0; i < RET_W; i++) begin
        if (ret_accept[i]) list[ret_slot[i]] <= retire_entry[i*IDX_W +: IDX_W];
      end
      tail     <= tail + ret_cnt[IDX_W-1:0];
      num_free <= (IDX_W+1)'(SUM_W'(num_free) - alloc_amt + ret_cnt);
    end
  end

`ifdef ENTRY_FREE_LIST_CHECK_EN
  // Allocated lanes leave the free set; accepted retires rejoin it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_free <= '1;
      err     <= 1'b0;
    end else if (flush) begin
      is_free <= '1;
      err     <= 1'b0;
    end else begin
      for (int k = 0; k < ALLOC_W; k++) begin
        if (alloc_grant && (CNT_W'(k) < alloc_req_cnt))
          is_free[alloc_entry[k*IDX_W +: IDX_W]] <= 1'b0;
      end
      for (int i = 0; i < RET_W; i++) begin
        if (ret_accept[i]) is_free[retire_entry[i*IDX_W +: IDX_W]] <= 1'b1;
      end
      if (ret_err) err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_entry_free_list.sv
`default_nettype none
// Directed self-checking bench for entry_free_list (DEPTH=16, ALLOC_W=2, RET_W=2).
module tb_entry_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] alloc_req_cnt;
  logic       alloc_grant;
  logic [7:0] alloc_entry;
  logic [1:0] retire_valid;
  logic [7:0] retire_entry;
  logic [4:0] num_free;
  logic       is_empty;
  logic       is_full;
  logic       err;

  int checks   = 0;
  int failures = 0;

  wire [3:0] lane0 = alloc_entry[3:0];
  wire [3:0] lane1 = alloc_entry[7:4];

  entry_free_list #(.DEPTH(16), .ALLOC_W(2), .RET_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_req_cnt(alloc_req_cnt), .alloc_grant(alloc_grant), .alloc_entry(alloc_entry),
    .retire_valid(retire_valid), .retire_entry(retire_entry),
    .num_free(num_free), .is_empty(is_empty), .is_full(is_full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; alloc_req_cnt = 2'd2; retire_valid = '0; retire_entry = '0;
    #2;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL rst_grant got=%0b exp=0", alloc_grant); end
    checks++; if (num_free !== 5'd16) begin failures++; $display("FAIL rst_num_free got=%0d exp=16", num_free); end
    checks++; if (is_empty !== 1'b1 || is_full !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=10", is_empty, is_full); end
    checks++; if (lane0 !== 4'd0 || lane1 !== 4'd1) begin failures++; $display("FAIL rst_lanes got=%0d,%0d exp=0,1", lane0, lane1); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
    alloc_req_cnt = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_alloc_drain();
    for (int c = 0; c < 8; c++) begin
      alloc_req_cnt = 2'd2;
      #1;
      checks++;
      if (alloc_grant !== 1'b1 || lane0 !== 4'(2*c) || lane1 !== 4'(2*c+1)) begin
        failures++;
        $display("FAIL drain_%0d got=g%0b %0d,%0d exp=g1 %0d,%0d", c, alloc_grant, lane0, lane1, 2*c, 2*c+1);
      end
      step();
    end
    alloc_req_cnt = '0;
    #1;
    checks++; if (num_free !== 5'd0 || is_full !== 1'b1 || is_empty !== 1'b0) begin failures++; $display("FAIL drain_full got=n%0d f%0b e%0b exp=n0 f1 e0", num_free, is_full, is_empty); end
    alloc_req_cnt = 2'd1;
    #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL drain_deny got=%0b exp=0", alloc_grant); end
    alloc_req_cnt = '0;
  endtask

  task automatic test_retire_from_full();
    retire_valid = 2'b10; retire_entry = {4'd5, 4'd12};
    step();
    retire_valid = '0;
    #1;
    checks++; if (num_free !== 5'd1 || is_full !== 1'b0) begin failures++; $display("FAIL ret_count got=%0d exp=1", num_free); end
    alloc_req_cnt = 2'd2;
    #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL ret_deny2 got=%0b exp=0", alloc_grant); end
    alloc_req_cnt = 2'd3;
    #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL ret_deny3 got=%0b exp=0", alloc_grant); end
    alloc_req_cnt = 2'd1;
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd5) begin failures++; $display("FAIL ret_alloc got=g%0b %0d exp=g1 5", alloc_grant, lane0); end
    step();
    alloc_req_cnt = '0;
    #1;
    checks++; if (num_free !== 5'd0) begin failures++; $display("FAIL ret_after got=%0d exp=0", num_free); end
  endtask

  task automatic test_simultaneous();
    retire_valid = 2'b01; retire_entry = {4'd0, 4'd2};
    step();
    retire_valid = '0;
    #1;
    checks++; if (num_free !== 5'd1) begin failures++; $display("FAIL sim_pre got=%0d exp=1", num_free); end
    alloc_req_cnt = 2'd1; retire_valid = 2'b11; retire_entry = {4'd9, 4'd7};
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd2) begin failures++; $display("FAIL sim_grant got=g%0b %0d exp=g1 2", alloc_grant, lane0); end
    step();
    retire_valid = '0; alloc_req_cnt = '0;
    #1;
    checks++; if (num_free !== 5'd2) begin failures++; $display("FAIL sim_count got=%0d exp=2", num_free); end
    alloc_req_cnt = 2'd2;
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd7 || lane1 !== 4'd9) begin failures++; $display("FAIL sim_lanes got=g%0b %0d,%0d exp=g1 7,9", alloc_grant, lane0, lane1); end
    alloc_req_cnt = 2'd1;
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd7) begin failures++; $display("FAIL sim_first got=g%0b %0d exp=g1 7", alloc_grant, lane0); end
    step();
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd9 || num_free !== 5'd1) begin failures++; $display("FAIL sim_second got=g%0b %0d n%0d exp=g1 9 n1", alloc_grant, lane0, num_free); end
    step();
    alloc_req_cnt = '0;
    #1;
    checks++; if (num_free !== 5'd0 || is_full !== 1'b1) begin failures++; $display("FAIL sim_end got=%0d exp=0", num_free); end
  endtask

  task automatic test_flush();
    flush = 1'b1; alloc_req_cnt = 2'd2; retire_valid = 2'b11; retire_entry = {4'd3, 4'd1};
    #1;
    checks++; if (alloc_grant !== 1'b0) begin failures++; $display("FAIL flush_grant got=%0b exp=0", alloc_grant); end
    step();
    flush = 1'b0; alloc_req_cnt = '0; retire_valid = '0;
    #1;
    checks++; if (num_free !== 5'd16 || is_empty !== 1'b1) begin failures++; $display("FAIL flush_count got=%0d exp=16", num_free); end
    checks++; if (lane0 !== 4'd0 || lane1 !== 4'd1) begin failures++; $display("FAIL flush_lanes got=%0d,%0d exp=0,1", lane0, lane1); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush_err got=%0b exp=0", err); end
  endtask

  task automatic test_async_reset();
    alloc_req_cnt = 2'd2;
    for (int c = 0; c < 5; c++) step();
    alloc_req_cnt = 2'd1;
    step();
    #1;
    checks++; if (lane0 !== 4'd11 || num_free !== 5'd5) begin failures++; $display("FAIL ar_head got=%0d n%0d exp=11 n5", lane0, num_free); end
    alloc_req_cnt = 2'd2;
    #1;
    rst = 1'b1;
    #1;
    checks++; if (num_free !== 5'd16 || lane0 !== 4'd0 || lane1 !== 4'd1 || alloc_grant !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got=n%0d %0d,%0d g%0b exp=n16 0,1 g0", num_free, lane0, lane1, alloc_grant);
    end
    step();
    rst = 1'b0;
    #1;
    checks++; if (alloc_grant !== 1'b1 || lane0 !== 4'd0 || lane1 !== 4'd1) begin failures++; $display("FAIL ar_first got=g%0b %0d,%0d exp=g1 0,1", alloc_grant, lane0, lane1); end
    step();
    alloc_req_cnt = '0;
    #1;
    checks++; if (num_free !== 5'd14 || err !== 1'b0) begin failures++; $display("FAIL ar_count got=%0d e%0b exp=14 e0", num_free, err); end
  endtask

`ifdef ENTRY_FREE_LIST_CHECK_EN
  task automatic test_check();
    flush = 1'b1;
    step();
    flush = 1'b0; alloc_req_cnt = 2'd2;
    step();
    alloc_req_cnt = '0; retire_valid = 2'b01; retire_entry = {4'd0, 4'd3};
    step();
    retire_valid = '0;
    #1;
    checks++; if (err !== 1'b1 || num_free !== 5'd14) begin failures++; $display("FAIL chk_free got=e%0b n%0d exp=e1 n14", err, num_free); end
    retire_valid = 2'b11; retire_entry = {4'd0, 4'd0};
    step();
    retire_valid = '0;
    step();
    checks++; if (err !== 1'b1 || num_free !== 5'd15) begin failures++; $display("FAIL chk_dup got=e%0b n%0d exp=e1 n15", err, num_free); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checks++; if (err !== 1'b0 || num_free !== 5'd16) begin failures++; $display("FAIL chk_clear got=e%0b n%0d exp=e0 n16", err, num_free); end
  endtask
`endif

  initial begin
    test_reset();
    test_alloc_drain();
    test_retire_from_full();
    test_simultaneous();
    test_flush();
    test_async_reset();
`ifdef ENTRY_FREE_LIST_CHECK_EN
    test_check();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/entry_free_list.md
# entry_free_list

Multi-port free-entry list for the store-queue/LSQ writeback path. It is the parametrised successor of the single-port free-entry FIFO. Per cycle it hands out up to `ALLOC_W` free entry indices to dispatch and accepts up to `RET_W` retired indices from writeback. It keeps an exact free count and has all-or-nothing allocation grants. Full reinitialisation on flush is synchronous.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; power of two, ≥ 4. `IDX_W = $clog2(DEPTH)`.
- `ALLOC_W`, 2: maximum allocations per cycle, 1..4, ≤ DEPTH.
- `RET_W`, 2: maximum retires per cycle, 1..4, ≤ DEPTH.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `flush`, in, 1: synchronous reinitialise; overrides all other inputs that cycle.
- `alloc_req_cnt`, in, `$clog2(ALLOC_W+1)`: number of entries requested this cycle (0..ALLOC_W).
- `alloc_grant`, out, 1: the whole request is granted this cycle.
- `alloc_entry`, out, `ALLOC_W*IDX_W`: lane k (bits `[k*IDX_W +: IDX_W]`) = k-th granted index.
- `retire_valid`, in, `RET_W`: per-lane retire strobe; lanes need not be contiguous.
- `retire_entry`, in, `RET_W*IDX_W`: per-lane index being freed.
- `num_free`, out, `IDX_W+1`: registered free count.
- `is_empty`, out, 1: all entries free (`num_free == DEPTH`).
- `is_full`, out, 1: no entries free (`num_free == 0`).
- `err`, out, 1: sticky error flag; see Configuration.

## Operation
- State:
  - circular array `list[DEPTH]` of IDX_W-bit indices
  - `head` (next index to hand out), IDX_W bits
  - `tail` (next slot to write), IDX_W bits
  - `num_free` register, IDX_W+1 bits
- Pointers wrap modulo DEPTH through natural IDX_W overflow.
- Reset and flush state:
  - `list[i] = i`, `head = 0`, `tail = 0`, `num_free = DEPTH`, `err = 0`.
- Grant rule:
  - `alloc_grant = !flush && alloc_req_cnt != 0 && alloc_req_cnt <= num_free`.
  - No partial grants.
  - A request with `alloc_req_cnt > ALLOC_W` is treated as ungranted.
- Allocation outputs:
  - `alloc_entry` lane k always shows `list[head+k]`, whether or not a grant occurs.
  - Consumers use only lanes `< alloc_req_cnt`, and only when `alloc_grant` is high.
- On a grant, `head` advances by `alloc_req_cnt` at the next edge.
- Retire:
  - Valid lanes are compacted in ascending lane order.
  - They are written to `list[tail]`, `list[tail+1]`, …
  - `tail` advances by `popcount(retire_valid)`.
- Count update: `num_free_next = num_free − (grant ? alloc_req_cnt : 0) + popcount(retire_valid)`.
- Simultaneous alloc and retire is legal. Retired indices are not bypassed to allocation in the same cycle.
- Flush takes priority over alloc and retire in the same cycle. Those requests are dropped, and `alloc_grant` is 0.

## Timing
- Allocation is combinational: `alloc_entry` and `alloc_grant` are valid in the same cycle as `alloc_req_cnt`.
- Pointer and count updates occur at the next rising edge.
- A retired index becomes allocatable 1 cycle after its retire cycle. It is allocatable only when it is the next entry at `head`; this is FIFO order.
- `num_free`, `is_empty` and `is_full` are registered-state derived. They reflect the cycle-N request and retire only from cycle N+1.
- Output values while `rst` is asserted:
  - `alloc_grant = 0`
  - `num_free = DEPTH`, `is_empty = 1`, `is_full = 0`
  - lane k of `alloc_entry = k`
  - `err = 0`
- Reset mid-operation discards all outstanding state immediately (asynchronous).
- The first grant is possible in the first cycle after `rst` deasserts.

## Configuration
- Macro: `ENTRY_FREE_LIST_CHECK_EN`.
- Defined:
  - The block keeps a DEPTH-bit `is_free` bitmap.
  - A retire lane whose index is already free, or duplicated in an earlier lane the same cycle, is dropped. It does not enter the list and does not change the count. The block sets `err`.
  - A retire that would push `num_free` above DEPTH is dropped the same way, with `err` set.
  - `err` is sticky; it clears only on `rst` or `flush`.
- Undefined:
  - No bitmap is built.
  - Every valid retire lane is appended unconditionally.
  - `err` is tied to 0.
  - Overflow behaviour is undefined; it is a caller bug.

## Test plan
- Reset, then `alloc_req_cnt=2` for 8 cycles (DEPTH=16) → grants return 0,1 / 2,3 / … / 14,15. `is_full=1` after the 8th edge. A 9th request with cnt=1 has `alloc_grant=0`.
- From full, retire lanes {1:5} only (`retire_valid=2'b10`) → next cycle `num_free=1`. Then `alloc_req_cnt=1` → `alloc_entry` lane0 = 5. A request with cnt=2 that cycle is denied.
- With `num_free=1`, alloc cnt=1 and retire 2 entries (7, 9) in the same cycle → grant; next cycle `num_free=2`. The next two grants return 7 then 9.
- Flush asserted together with alloc cnt=2 and retire of 3 → `alloc_grant=0` that cycle. Next cycle `num_free=16`, `head=0`, and lanes show 0,1.
- `rst` pulsed mid-stream while `head=11` → outputs immediately show `num_free=16` and lanes 0,1. The first post-reset grant returns 0,1.
- `ENTRY_FREE_LIST_CHECK_EN` defined: retire index 3 while it is free, or the same index on both lanes → `err=1`, count unchanged by the dropped lane(s), `err` holds until flush.
